// File: rtl/note_matcher_multi_if.sv
// note_matcher_multi_if: bundles the metadata-fetch and scoring-side signals
// of the multi-lane note matcher.
//   pause          freeze all lanes, discard press edges
//   song_time      current song position (TW bits)
//   ndata          raw key state per lane, 1 = pressed
//   note_time      next note time per lane, lane i at [i*TW +: TW]
//   note_available note_time of lane i is valid
//   note_request   one-cycle request for the next note of lane i
//   match_trigger  one-cycle hit pulse per lane
//   match_delta    signed offset song_time - target per lane, held
//   match_grade    11 perfect, 10 good, 00 miss per lane, held
//   miss_trigger   one-cycle miss pulse per lane
//   lane_done      lane reached end of song
// Modport master is the upstream/stimulus side, slave is the matcher.
interface note_matcher_multi_if #(
  parameter int NCH = 37,
  parameter int TW  = 16
);
  logic              pause;
  logic [TW-1:0]     song_time;
  logic [NCH-1:0]    ndata;
  logic [NCH*TW-1:0] note_time;
  logic [NCH-1:0]    note_available;
  logic [NCH-1:0]    note_request;
  logic [NCH-1:0]    match_trigger;
  logic [NCH*TW-1:0] match_delta;
  logic [NCH*2-1:0]  match_grade;
  logic [NCH-1:0]    miss_trigger;
  logic [NCH-1:0]    lane_done;

  modport master (
    output pause, song_time, ndata, note_time, note_available,
    input  note_request, match_trigger, match_delta, match_grade,
           miss_trigger, lane_done
  );

  modport slave (
    input  pause, song_time, ndata, note_time, note_available,
    output note_request, match_trigger, match_delta, match_grade,
           miss_trigger, lane_done
  );
endinterface

// File: rtl/note_matcher_multi.sv
// note_matcher_multi: NCH independent matcher lanes. Each lane requests its
// next note time, arms a [target-WIN_EARLY, target+WIN_LATE] window, and grades
// the first key press edge inside it (hit) or flags a miss once song_time
// passes the window. An all-ones note time marks end of song for the lane.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      note_matcher_multi_if.slave (see interface header)
module note_matcher_multi #(
  parameter int NCH         = 37,
  parameter int TW          = 16,
  parameter int WIN_EARLY   = 40,
  parameter int WIN_LATE    = 40,
  parameter int PERFECT_WIN = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  note_matcher_multi_if.slave   bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ARMED, S_DONE} state_t;

  // Window arithmetic is done in TW+1 bits so clamping/saturation is exact.
  localparam logic [TW:0] EARLY = (TW+1)'(WIN_EARLY);
  localparam logic [TW:0] LATE  = (TW+1)'(WIN_LATE);
  localparam logic [TW:0] PERF  = (TW+1)'(PERFECT_WIN);
  localparam logic [TW:0] TOP   = {1'b0, {TW{1'b1}}};

  logic [NCH-1:0] prev_q;

  // Tracks ndata even while paused, so a key pressed during pause has no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= bus.ndata;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    state_t        state_q, state_d;
    logic [TW-1:0] target_q, target_d;
    logic [TW-1:0] delta_q, delta_d;
    logic [1:0]    grade_q, grade_d;
    logic          req_q, req_d, hit_q, hit_d, miss_q, miss_d;
    logic [TW:0]   tgt, now, lo, hi, hi_raw, diff_u, mag;
    logic          press;
    logic [TW-1:0] nt;

    assign nt     = bus.note_time[i*TW +: TW];
    assign tgt    = {1'b0, target_q};
    assign now    = {1'b0, bus.song_time};
    assign lo     = (tgt < EARLY) ? '0 : tgt - EARLY;
    assign hi_raw = tgt + LATE;
    assign hi     = (hi_raw > TOP) ? TOP : hi_raw;
    assign diff_u = now - tgt;
    assign mag    = diff_u[TW] ? (~diff_u + 1'b1) : diff_u;
    assign press  = bus.ndata[i] & ~prev_q[i];

    always_comb begin
      state_d  = state_q;
      target_d = target_q;
      delta_d  = delta_q;
      grade_d  = grade_q;
      req_d    = 1'b0;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      if (!bus.pause) begin
        unique case (state_q)
          S_REQ: begin
            req_d   = 1'b1;
            state_d = S_WAIT;
          end
          S_WAIT: begin
            if (bus.note_available[i]) begin
              target_d = nt;
              state_d  = (&nt) ? S_DONE : S_ARMED;
            end
          end
          S_ARMED: begin
            // Hit takes priority: window bounds are inclusive.
            if (press && now >= lo && now <= hi) begin
              hit_d   = 1'b1;
              delta_d = diff_u[TW-1:0];
              grade_d = (mag <= PERF) ? 2'b11 : 2'b10;
              state_d = S_REQ;
            end else if (now > hi) begin
              miss_d  = 1'b1;
              grade_d = 2'b00;
              state_d = S_REQ;
            end
          end
          S_DONE: ;
          default: state_d = S_REQ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= S_REQ;
        target_q <= '0;
        delta_q  <= '0;
        grade_q  <= '0;
        req_q    <= 1'b0;
        hit_q    <= 1'b0;
        miss_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        target_q <= target_d;
        delta_q  <= delta_d;
        grade_q  <= grade_d;
        req_q    <= req_d;
        hit_q    <= hit_d;
        miss_q   <= miss_d;
      end
    end

    assign bus.note_request[i]            = req_q;
    assign bus.match_trigger[i]           = hit_q;
    assign bus.miss_trigger[i]            = miss_q;
    assign bus.match_delta[i*TW +: TW]    = delta_q;
    assign bus.match_grade[i*2 +: 2]      = grade_q;
    assign bus.lane_done[i]               = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_note_matcher_multi.sv
// tb_note_matcher_multi: directed-vector bench for note_matcher_multi.
module tb_note_matcher_multi;
  localparam int NCH = 37;
  localparam int TW  = 16;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  note_matcher_multi_if #(.NCH(NCH), .TW(TW)) bus ();

  note_matcher_multi #(
    .NCH(NCH), .TW(TW), .WIN_EARLY(40), .WIN_LATE(40), .PERFECT_WIN(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [NCH-1:0] ALL = {NCH{1'b1}};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [NCH-1:0] mask, input logic [TW-1:0] t);
    for (int i = 0; i < NCH; i++)
      if (mask[i]) bus.note_time[i*TW +: TW] = t;
    bus.note_available = mask;
    tick();
    bus.note_available = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.pause          = 1'b0;
    bus.song_time      = '0;
    bus.ndata          = '0;
    bus.note_time      = '0;
    bus.note_available = '0;
    #3;
    check_val("rst_req",   bus.note_request,  0);
    check_val("rst_trig",  bus.match_trigger, 0);
    check_val("rst_miss",  bus.miss_trigger,  0);
    check_val("rst_done",  bus.lane_done,     0);
    tick();
    reset_n = 1'b1;
    tick();
    check_val("first_req", bus.note_request, ALL);
    tick();
    check_val("req_one_cycle", bus.note_request, 0);

    // Hit +5, perfect
    serve(1, 16'd1000);
    bus.song_time = 16'd1005; bus.ndata = 1;
    tick();
    check_val("hit5_trig",  bus.match_trigger, 1);
    check_val("hit5_delta", bus.match_delta[15:0], 16'h0005);
    check_val("hit5_grade", bus.match_grade[1:0], 2'b11);
    bus.ndata = 0;
    tick();
    check_val("hit5_pulse", bus.match_trigger, 0);
    check_val("hit5_req",   bus.note_request, 1);

    // Stray press at 959, then good hit at 975
    serve(1, 16'd1000);
    bus.song_time = 16'd959; bus.ndata = 1;
    tick();
    check_val("stray_trig", bus.match_trigger, 0);
    check_val("stray_miss", bus.miss_trigger, 0);
    bus.ndata = 0;
    tick();
    bus.song_time = 16'd975; bus.ndata = 1;
    tick();
    check_val("early_trig",  bus.match_trigger, 1);
    check_val("early_delta", bus.match_delta[15:0], 16'hFFE7);
    check_val("early_grade", bus.match_grade[1:0], 2'b10);
    bus.ndata = 0;
    tick();

    // Miss once song_time passes 1040
    serve(1, 16'd1000);
    bus.song_time = 16'd1040;
    tick();
    check_val("late_edge_nomiss", bus.miss_trigger, 0);
    bus.song_time = 16'd1041;
    tick();
    check_val("miss_trig",  bus.miss_trigger, 1);
    check_val("miss_notrig", bus.match_trigger, 0);
    check_val("miss_grade", bus.match_grade[1:0], 2'b00);
    check_val("miss_delta_held", bus.match_delta[15:0], 16'hFFE7);
    tick();
    check_val("miss_pulse", bus.miss_trigger, 0);
    check_val("miss_req",   bus.note_request, 1);

    // Target 20, lo clamps to 0
    bus.song_time = 16'd0;
    serve(1, 16'd20);
    bus.ndata = 1;
    tick();
    check_val("lo0_trig",  bus.match_trigger, 1);
    check_val("lo0_delta", bus.match_delta[15:0], 16'hFFEC);
    bus.ndata = 0;
    tick();

    // Target 0xFFF0, hi saturates to 0xFFFF
    bus.song_time = 16'hFFFF;
    serve(1, 16'hFFF0);
    bus.ndata = 1;
    tick();
    check_val("sat_trig",  bus.match_trigger, 1);
    check_val("sat_miss",  bus.miss_trigger, 0);
    check_val("sat_delta", bus.match_delta[15:0], 16'h000F);
    check_val("sat_grade", bus.match_grade[1:0], 2'b10);
    bus.ndata = 0;
    tick();

    // Key held from before the window: no hit, then miss
    serve(1, 16'd1000);
    bus.song_time = 16'd900; bus.ndata = 1;
    tick();
    bus.song_time = 16'd1000;
    tick();
    check_val("held_notrig", bus.match_trigger, 0);
    bus.song_time = 16'd1041;
    tick();
    check_val("held_miss", bus.miss_trigger, 1);
    bus.ndata = 0;
    tick();

    // Press during pause, resume: no hit, late miss only after resume
    bus.song_time = 16'd1000;
    serve(1, 16'd1000);
    bus.pause = 1'b1; bus.ndata = 1;
    tick();
    check_val("pause_notrig", bus.match_trigger, 0);
    bus.song_time = 16'd1041;
    tick();
    check_val("pause_nomiss", bus.miss_trigger, 0);
    bus.pause = 1'b0;
    tick();
    check_val("resume_notrig", bus.match_trigger, 0);
    check_val("resume_miss",   bus.miss_trigger, 1);
    bus.ndata = 0;
    tick();

    // All lanes hit in the same cycle
    bus.song_time = 16'd1000;
    serve(ALL, 16'd1000);
    bus.ndata = ALL;
    tick();
    check_val("all_trig",   bus.match_trigger, ALL);
    check_val("all_grade36", bus.match_grade[NCH*2-1 -: 2], 2'b11);
    bus.ndata = '0;
    tick();
    check_val("all_req", bus.note_request, ALL);

    // End-of-song sentinel on lane 0
    serve(1, 16'hFFFF);
    check_val("done_lane0", bus.lane_done, 1);
    tick();
    tick();
    check_val("done_noreq", bus.note_request, 0);

    // Reset while lane 1 is armed and being pressed
    serve(2, 16'd1000);
    bus.ndata = 2;
    reset_n = 1'b0;
    #1;
    check_val("arst_trig",  bus.match_trigger, 0);
    check_val("arst_done",  bus.lane_done, 0);
    check_val("arst_grade", bus.match_grade, 0);
    check_val("arst_delta", bus.match_delta, 0);
    tick();
    check_val("arst_hold_trig", bus.match_trigger, 0);
    bus.ndata = '0;
    reset_n = 1'b1;
    tick();
    check_val("arst_req", bus.note_request, ALL);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/note_matcher_multi.md
Name: note_matcher_multi

Overview:
- Parametrised successor to the per-song note-matching array: one matcher lane per fret/key channel.
- Each lane fetches its next scheduled note time from the metadata stage, watches its key input for press edges, and grades each press against that note.
- Reports hits with signed timing offset and grade; reports misses when a note expires unpressed.
- Sits between the note-metadata fetch stage and the scoring/display logic.

Parameters:
- NCH, 37, number of independent note channels.
- TW, 16, width of song_time and note times, in song ticks.
- WIN_EARLY, 40, ticks before the note time at which a press still counts.
- WIN_LATE, 40, ticks after the note time at which a press still counts.
- PERFECT_WIN, 10, maximum absolute offset graded perfect; must be <= min(WIN_EARLY, WIN_LATE).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pause  in  1  freezes all lane FSMs and discards press edges.
- song_time  in  TW  current song position, monotonic non-decreasing.
- ndata  in  NCH  raw key state per channel, 1 = pressed.
- note_time  in  NCH*TW  next note time per channel; lane i uses bits [i*TW +: TW].
- note_available  in  NCH  note_time[i] is valid.
- note_request  out  NCH  one-cycle pulse requesting the next note for lane i.
- match_trigger  out  NCH  one-cycle hit pulse.
- match_delta  out  NCH*TW  two's-complement offset song_time - target; held until the next hit.
- match_grade  out  NCH*2  11 = perfect, 10 = good, 00 = miss; held until the next event.
- miss_trigger  out  NCH  one-cycle miss pulse.
- lane_done  out  NCH  lane has reached end of song.

Behaviour:
- Reset (async, reset_n = 0): all lanes go to REQ.
  - All outputs 0; edge-detect registers 0.
  - Asserting reset mid-operation aborts any held note; no trigger is emitted.
- Edge detect: prev[i] <= ndata[i] every cycle, including during pause. edge[i] = ndata[i] & ~prev[i].
- Per-lane FSM:
  - REQ: assert note_request[i] for exactly one cycle, then go to WAIT.
  - WAIT: on note_available[i] = 1, latch target = note_time[i].
    - If target = all ones (end-of-song sentinel), go to DONE.
    - Otherwise go to ARMED.
    - No timeout in WAIT.
  - ARMED: compute window in TW+1 bits.
    - lo = target - WIN_EARLY, clamped at 0.
    - hi = target + WIN_LATE, saturated at 2^TW - 1.
    - If edge[i] and lo <= song_time <= hi (both bounds inclusive): hit.
      - match_trigger[i] = 1 for one cycle.
      - match_delta = song_time - target.
      - Grade = 11 if |delta| <= PERFECT_WIN, else 10.
      - Go to REQ.
    - Else if song_time > hi: miss.
      - miss_trigger[i] = 1 for one cycle; grade = 00.
      - Go to REQ.
    - An edge with song_time < lo is a stray press: ignored, no output, state unchanged.
  - DONE: lane_done[i] = 1; the lane stays idle until reset.
- Latency: edge on ndata at cycle n produces match_trigger at cycle n+1, registered. A miss is flagged the cycle after song_time first exceeds hi.
- Simultaneous events:
  - A hit and the late boundary in the same cycle are resolved as a hit, since the window is inclusive.
  - match_trigger and miss_trigger are never both high on one lane.
- Pause = 1:
  - The FSM holds state.
  - Edges are discarded; prev still tracks ndata, so a key pressed during pause does not hit on resume.
  - No request, hit or miss pulses.
  - A note_available arriving in WAIT while paused is not consumed until pause = 0.
- Lanes are fully independent; any number may trigger in the same cycle.
- The next note_request follows a hit or miss by exactly one cycle (REQ state).

Test Plan:
- Reset then release, single lane: note_request pulses one cycle at the first clk after release. Present note_time = 1000 with available. Press at song_time 1005 -> match_trigger next cycle, delta = +5, grade = 11, then a new note_request.
- Press at song_time 975 for target 1000 (lo = 960) -> hit, delta = -25 (0xFFE7), grade = 10. Press at 959 -> ignored, no trigger.
- No press, target 1000: song_time steps 1040 -> 1041 -> miss_trigger one cycle after 1041 appears, grade = 00, then note_request.
- Boundaries:
  - Target 20: lo clamps to 0; press at 0 -> hit, delta = -20.
  - Target 0xFFF0: hi saturates at 0xFFFF; press at 0xFFFF -> hit.
  - note_time = 0xFFFF -> lane_done = 1 and no further requests.
- Hold key from before the window through the window -> no hit (no edge), then a miss. Press during pause inside the window, then resume -> no hit.
- All 37 lanes pressed in the same cycle within their windows -> 37 simultaneous match_triggers. Assert reset_n low mid-ARMED -> outputs 0 immediately, with no trigger pulses.
